// File: rtl/record_byte_serializer.sv
// record_byte_serializer
// Accepts one typed record (kind, tag, payload) per input handshake and
// emits it as a framed byte stream: tag, header {kind, len}, then len
// payload bytes least-significant first. Reserved kinds are consumed,
// dropped and counted.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - record handshake
//   in_kind         - 0=NULL, 1=BYTE, 2=INT, 3=RSVD
//   in_tag          - record tag byte
//   in_data         - payload, byte 0 in bits [7:0]
//   out_valid/ready - byte handshake
//   out_byte        - stream byte
//   out_last        - final byte of the frame
//   err_count       - dropped reserved records, saturating at 255
module record_byte_serializer #(
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_kind,
    input  logic [7:0]              in_tag,
    input  logic [8*DATA_BYTES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_byte,
    output logic                    out_last,
    output logic [7:0]              err_count
);

    localparam int unsigned DW      = 8 * DATA_BYTES;
    localparam logic [5:0]  INT_LEN = 6'(DATA_BYTES);

    localparam logic [1:0] K_NULL = 2'd0;
    localparam logic [1:0] K_BYTE = 2'd1;
    localparam logic [1:0] K_INT  = 2'd2;
    localparam logic [1:0] K_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAG     = 2'd1,
        HDR     = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      hold_kind;
    logic [7:0]      hold_tag;
    logic [DW-1:0]   hold_data;
    logic [5:0]      hold_len;
    logic [5:0]      idx;

    // Payload length implied by the record kind.
    function automatic logic [5:0] len_of(input logic [1:0] kind);
        case (kind)
            K_NULL:  len_of = 6'd0;
            K_BYTE:  len_of = 6'd1;
            K_INT:   len_of = INT_LEN;
            default: len_of = 6'd0;
        endcase
    endfunction

    // Select payload byte i (byte 0 = least significant).
    function automatic logic [7:0] data_byte(input logic [DW-1:0] d, input logic [5:0] i);
        data_byte = 8'(d >> {i, 3'b000});
    endfunction

    // Ready is gated by rst so nothing is accepted in a reset cycle.
    assign in_ready = (state == IDLE) && !rst;

    // Frame sequencer; every output update is staged one cycle ahead so the
    // outputs come straight from flops and hold until their handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            err_count <= 8'h00;
            hold_kind <= 2'd0;
            hold_tag  <= 8'h00;
            hold_data <= '0;
            hold_len  <= 6'd0;
            idx       <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_kind == K_RSVD) begin
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end else begin
                            hold_kind <= in_kind;
                            hold_tag  <= in_tag;
                            hold_data <= in_data;
                            hold_len  <= len_of(in_kind);
                            out_valid <= 1'b1;
                            out_byte  <= in_tag;
                            out_last  <= 1'b0;
                            state     <= TAG;
                        end
                    end
                end
                TAG: begin
                    if (out_ready) begin
                        out_byte <= {hold_kind, hold_len};
                        out_last <= (hold_len == 6'd0);
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        if (hold_len == 6'd0) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idx      <= 6'd0;
                            out_byte <= data_byte(hold_data, 6'd0);
                            out_last <= (hold_len == 6'd1);
                            state    <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idx      <= idx + 6'd1;
                            out_byte <= data_byte(hold_data, idx + 6'd1);
                            out_last <= ((idx + 6'd2) == hold_len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // hold_tag is kept for debug visibility of the in-flight record.
    logic unused_ok;
    assign unused_ok = ^hold_tag;

endmodule
